branch_cmp_ctrl: RTL

- Controls the ID-stage branch comparator of the 5-stage MIPS pipeline.
- Keeps a small scoreboard of in-flight register writes in the E, M and W stages.
- From that scoreboard it stalls ID when a beq/bne operand is not yet produced, and selects the forwarding source for each comparator input.
- It then turns the comparator's Equal result into a branch-taken decision for the NPC logic.

---
 rtl/branch_cmp_ctrl_if.sv | 29 ++
 rtl/branch_cmp_ctrl.sv | 101 ++++++++++
 2 files changed

// File: rtl/branch_cmp_ctrl_if.sv
// ID-stage branch comparator control bundle: ID instruction fields and comparator result in,
// stall / forwarding selects / branch decision out.
interface branch_cmp_ctrl_if #(
    parameter int TNEW_W = 2
) ();
    logic              id_valid;
    logic              id_branch;
    logic              id_bne;
    logic [4:0]        id_rs;
    logic [4:0]        id_rt;
    logic              id_we;
    logic [4:0]        id_wa;
    logic [TNEW_W-1:0] id_tnew;
    logic              equal;
    logic              stall;
    logic [1:0]        fwd_sel_rs;
    logic [1:0]        fwd_sel_rt;
    logic              branch_taken;

    modport master (
        output id_valid, id_branch, id_bne, id_rs, id_rt, id_we, id_wa, id_tnew, equal,
        input  stall, fwd_sel_rs, fwd_sel_rt, branch_taken
    );

    modport slave (
        input  id_valid, id_branch, id_bne, id_rs, id_rt, id_we, id_wa, id_tnew, equal,
        output stall, fwd_sel_rs, fwd_sel_rt, branch_taken
    );
endinterface

// File: rtl/branch_cmp_ctrl.sv
// Branch comparator controller: E/M/W write scoreboard driving ID stall, operand forwarding
// selects and the same-cycle branch-taken decision for the next-PC logic.
module branch_cmp_ctrl #(
    parameter int TNEW_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    branch_cmp_ctrl_if.slave bus
);

    typedef struct packed {
        logic              v;
        logic [4:0]        wa;
        logic [TNEW_W-1:0] tnew;
    } sb_entry_t;

    localparam sb_entry_t BUBBLE = '{v: 1'b0, wa: 5'd0, tnew: {TNEW_W{1'b0}}};

    sb_entry_t   e_r;
    sb_entry_t   m_r;
    sb_entry_t   w_r;
    sb_entry_t   id_entry_s;
    logic [2:0]  rs_res_s;
    logic [2:0]  rt_res_s;
    logic        need_s;
    logic        stall_s;
    logic        cond_s;
    logic [1:0]  sel_rs_s;
    logic [1:0]  sel_rt_s;
    logic        taken_s;

    // Advance one pipeline stage: the result is one cycle closer, never below zero.
    function automatic sb_entry_t age(input sb_entry_t e);
        sb_entry_t a;
        a = e;
        if (e.tnew != {TNEW_W{1'b0}}) begin
            a.tnew = e.tnew - TNEW_W'(1'b1);
        end else begin
            a.tnew = {TNEW_W{1'b0}};
        end
        return a;
    endfunction

    // Returns {not_ready, sel}. Only the youngest matching stage is consulted; a pending
    // producer reports sel = 0 since the stall masks the operand anyway.
    function automatic logic [2:0] resolve(input logic [4:0] r, input sb_entry_t e,
                                           input sb_entry_t m, input sb_entry_t w);
        logic [2:0] res;
        if (r == 5'd0) begin
            res = 3'b000;
        end else if (e.v && (e.wa == r)) begin
            res = (e.tnew != {TNEW_W{1'b0}}) ? 3'b100 : 3'b001;
        end else if (m.v && (m.wa == r)) begin
            res = (m.tnew != {TNEW_W{1'b0}}) ? 3'b100 : 3'b010;
        end else if (w.v && (w.wa == r)) begin
            res = (w.tnew != {TNEW_W{1'b0}}) ? 3'b100 : 3'b011;
        end else begin
            res = 3'b000;
        end
        return res;
    endfunction

    // Hazard detection, forwarding selection and branch resolution from current scoreboard.
    always_comb begin
        rs_res_s   = resolve(bus.id_rs, e_r, m_r, w_r);
        rt_res_s   = resolve(bus.id_rt, e_r, m_r, w_r);
        need_s     = bus.id_valid & bus.id_branch;
        stall_s    = need_s & (rs_res_s[2] | rt_res_s[2]);
        cond_s     = bus.id_bne ? ~bus.equal : bus.equal;
        taken_s    = need_s & ~stall_s & cond_s;
        id_entry_s = '{v:    bus.id_valid & bus.id_we & (bus.id_wa != 5'd0),
                       wa:   bus.id_wa,
                       tnew: bus.id_tnew};
        if (bus.id_valid) begin
            sel_rs_s = rs_res_s[1:0];
            sel_rt_s = rt_res_s[1:0];
        end else begin
            sel_rs_s = 2'd0;
            sel_rt_s = 2'd0;
        end
    end

    // Scoreboard shift: a stalled ID instruction is held back and a bubble enters E instead.
    always_ff @(posedge clk) begin
        if (reset) begin
            e_r <= BUBBLE;
            m_r <= BUBBLE;
            w_r <= BUBBLE;
        end else begin
            e_r <= stall_s ? BUBBLE : id_entry_s;
            m_r <= age(e_r);
            w_r <= age(m_r);
        end
    end

    assign bus.stall        = stall_s;
    assign bus.fwd_sel_rs   = sel_rs_s;
    assign bus.fwd_sel_rt   = sel_rt_s;
    assign bus.branch_taken = taken_s;

endmodule
